// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the execute-stage multiply/divide unit.
// Contents:
//   md_op_t     - mul/div opcode (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   MD_DIV_ITER - radix-2 divide iterations, one per quotient bit
//   abs32       - two's-complement magnitude of a 32-bit value
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } md_op_t;

    localparam int MD_DIV_ITER = 32;

    // 0x80000000 maps to itself; read as unsigned that is 2^31, which is
    // exactly the magnitude the divider needs.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring radix-2 division iteration (purely combinational).
// Ports:
//   rem_i/quo_i - current partial remainder and dividend/quotient shift reg
//   dvs_i       - divisor magnitude
//   rem_o/quo_o - state after shifting left by one and trial-subtracting
module div_radix2_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        rem_sh = {rem_i, quo_i[31]};
        diff   = rem_sh - {1'b0, dvs_i};
        // Partial remainder stays below the divisor, so bit 32 of the
        // difference is a clean borrow flag. A zero divisor always
        // "fits", yielding an all-ones quotient and rem = dividend.
        if (!diff[32]) begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = rem_sh[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   op_valid_i, op_i      - E-stage mul/div instruction and its opcode
//   a_i, b_i              - rs (dividend/multiplicand), rt (divisor/multiplier)
//   cancel_i              - exception flush, aborts any operation
//   pipe_stall_i          - E stage held; keeps the result in DONE
//   busy_o                - stall request to the hazard unit (combinational)
//   res_valid_o           - hi_o/lo_o hold the current instruction's result
//   hi_o, lo_o            - remainder/upper product, quotient/lower product
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  md_op_t      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    input  logic        pipe_stall_i,
    output logic        busy_o,
    output logic        res_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(((MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER) + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    md_op_t        op_q;
    logic [31:0]   a_q, b_q, rem_q, quo_q, hi_q, lo_q;
    logic          qneg_q, rneg_q;
    logic          busy, accept, is_div, sgn_div;
    logic [31:0]   rem_n, quo_n;
    logic [63:0]   prod_u, prod_s, prod;

    assign accept  = (state == S_IDLE) && op_valid_i && !cancel_i;
    assign is_div  = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign sgn_div = (op_i == MD_DIV);

    div_radix2_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (b_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    // Product is formed from the latched operands; the MUL_LAT cycles in
    // MUL give synthesis room to retime the multiplier.
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod_s = $unsigned($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
    assign prod   = (op_q == MD_MULT) ? prod_s : prod_u;

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        case (state)
            S_IDLE: if (op_valid_i) begin
                busy    = 1'b1;
                state_n = is_div ? S_DIV : S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (cnt == CW'(MUL_LAT - 1)) state_n = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (cnt == CW'(DIV_ITER - 1)) state_n = S_DONE;
            end
            S_DONE: if (!pipe_stall_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Flush wins everywhere: drop the stall this cycle, discard work.
        if (cancel_i) begin
            busy    = 1'b0;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= MD_NONE;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                op_q   <= op_i;
                a_q    <= sgn_div ? abs32(a_i) : a_i;
                b_q    <= sgn_div ? abs32(b_i) : b_i;
                rem_q  <= '0;
                quo_q  <= sgn_div ? abs32(a_i) : a_i;
                qneg_q <= sgn_div & (a_i[31] ^ b_i[31]);
                rneg_q <= sgn_div & a_i[31];
            end
            if (state == S_MUL) begin
                cnt <= cnt + 1'b1;
                if (state_n == S_DONE) {hi_q, lo_q} <= prod;
            end
            if (state == S_DIV) begin
                cnt   <= cnt + 1'b1;
                rem_q <= rem_n;
                quo_q <= quo_n;
                if (state_n == S_DONE) begin
                    lo_q <= qneg_q ? (32'd0 - quo_n) : quo_n;
                    hi_q <= rneg_q ? (32'd0 - rem_n) : rem_n;
                end
            end
        end
    end

    assign busy_o      = busy;
    assign res_valid_o = (state == S_DONE);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit in the execute stage of each issue slot. It accepts one MULT/MULTU/DIV/DIVU per instruction and produces a 64-bit {hi, lo} result. While the operation is in flight it raises `busy_o`, which is wired straight into the hazard unit's `alu_stallE`. That input freezes every pipeline stage until the result is ready. It aborts immediately on an exception flush.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles spent in MUL state (≥1).
- `DIV_ITER`, default 32: radix-2 iterations (one per quotient bit).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `op_valid_i`  in  1  E-stage instruction is a mul/div (DivMulEn) and not flushed.
- `op_i`  in  md_op_t  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- `a_i`  in  32  rs operand (dividend / multiplicand).
- `b_i`  in  32  rt operand (divisor / multiplier).
- `cancel_i`  in  1  exception flush (hazard `fulsh_ex`); aborts the operation.
- `pipe_stall_i`  in  1  E stage held by a cache stall; result must be kept.
- `busy_o`  out  1  to hazard `alu_stallE`.
- `res_valid_o`  out  1  `hi_o`/`lo_o` hold the result of the current E instruction.
- `hi_o`  out  32  remainder (div) or upper product (mul).
- `lo_o`  out  32  quotient (div) or lower product (mul).

## Operation
- FSM states are IDLE, MUL, DIV and DONE; reset state is IDLE.
- **IDLE:**
  - If `op_valid_i & ~cancel_i`, latch operands and op. Go to MUL or DIV, and load the iteration counter with 0.
  - Division latches |a|, |b| for signed ops, plus the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
- **MUL:**
  - Compute the full 64-bit product: signed for MULT, unsigned for MULTU. MUL_LAT-stage retiming is permitted.
  - Counter reaches MUL_LAT-1 → DONE, with {hi,lo} registered.
- **DIV:**
  - One restoring step per cycle: shift {rem, quo} left by 1 and trial-subtract the divisor.
  - Counter reaches DIV_ITER-1 → DONE. Apply sign correction on entry to DONE: negate quo if the quotient sign is set; negate rem if the remainder sign is set.
- **DONE:**
  - `res_valid_o` = 1; hi/lo are held.
  - `~pipe_stall_i` → IDLE.
  - `op_valid_i` is ignored here, because it is the same instruction.
- `busy_o` = ~`cancel_i` & ((IDLE & `op_valid_i`) | MUL | DIV). It is combinational so the accept cycle itself stalls.
- `cancel_i` in any state → IDLE on the next edge. `busy_o` drops in the same cycle; partial results are discarded.
- Divide by zero is defined behaviour, not an exception:
  - Unsigned: quo = 0xFFFFFFFF, rem = a.
  - Signed: the result after sign correction, deterministic and no hang.
- 0x80000000 / 0xFFFFFFFF (DIV) gives lo = 0x80000000, hi = 0.
- `pipe_stall_i` does not pause MUL/DIV iterations; it only extends DONE.

## Timing
- **Reset values:** `busy_o` = 0, `res_valid_o` = 0, `hi_o` = `lo_o` = 0, counter = 0.
- **Mul:** `busy_o` is high for 1+MUL_LAT cycles, i.e. 3 by default. `res_valid_o` rises in the cycle after `busy_o` falls.
- **Div:** `busy_o` is high for 1+DIV_ITER = 33 cycles; `res_valid_o` follows.
- **Back-to-back ops:** a new op is accepted no earlier than the cycle after leaving DONE.
- **Simultaneous events:**
  - `cancel_i` together with `op_valid_i` in IDLE: not accepted.
  - `cancel_i` in DONE: → IDLE; `res_valid_o` drops next cycle.
- **Reset mid-operation:** immediate return to reset values (asynchronous).

## Structure
- Shared CPU package holds:
  - `md_op_t` (3-bit enum including MD_NONE);
  - the constant MD_DIV_ITER = 32;
  - the helper function `abs32`.
- Sub-module `div_radix2_step` is combinational: one shift-subtract iteration taking {rem, quo, divisor} and producing the next {rem, quo}. The FSM, counter, sign handling and multiplier live in `muldiv_unit`.

## Test plan
- **DIVU:** a=100, b=7 → `busy_o` high 33 cycles, then hi=2, lo=14, `res_valid_o`=1.
- **DIV:** a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **MULT / MULTU:** a=0xFFFFFFFF, b=2.
  - MULT → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU → hi=1, lo=0xFFFFFFFE.
  - In both cases `busy_o` is high exactly 3 cycles.
- **DIVU by zero:** a=0x1234, b=0 → hi=0x1234, lo=0xFFFFFFFF after 33 cycles, no hang.
- **Cancel mid-divide:** `cancel_i` pulsed at iteration 10 → `busy_o`=0 in that cycle, IDLE next. The following DIVU 9/3 yields lo=3, hi=0.
- **Stall in DONE:** `pipe_stall_i` held 5 cycles in DONE → hi/lo and `res_valid_o` stable for all 5; IDLE one cycle after release. Also assert `rst` mid-DIV → all outputs 0 immediately.
